// File: rtl/mem_port_arbiter.sv
// Three-way round-robin arbiter for a single-port sync RAM: loader (write), fetch (read),
// data path (read/write), with a loader lock and a one-cycle ack pulse per transaction.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              restart,
    input  logic [2:0]        req,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata2,
    input  logic              lock,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        winner_q, winner_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        ack_q, ack_d;
    logic [2:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    function automatic logic [1:0] rr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search order starts just after the last winner; lock masks everyone but the loader.
    logic [2:0] elig;
    logic [1:0] cand0, cand1, pick;
    always_comb begin
        elig  = lock ? {2'b00, req[0]} : req;
        cand0 = rr_inc(rr_q);
        cand1 = rr_inc(cand0);
        if (elig[cand0])      pick = cand0;
        else if (elig[cand1]) pick = cand1;
        else                  pick = rr_q;
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        ack_d       = 3'b000;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    winner_d = pick;
                    grant_d  = 3'b001 << pick;
                    mem_en_d = 1'b1;
                    state_d  = S_ISSUE;
                    case (pick)
                        2'd0: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr0;
                            mem_wdata_d = wdata0;
                        end
                        2'd1: begin
                            mem_we_d   = 1'b0;
                            mem_addr_d = addr1;
                        end
                        default: begin
                            mem_we_d    = we2;
                            mem_addr_d  = addr2;
                            mem_wdata_d = wdata2;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    ack_d   = grant_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = mem_rdata;
                    ack_d   = grant_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                rr_d    = winner_q;
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q     <= S_IDLE;
            winner_q    <= 2'd0;
            rr_q        <= 2'd2;
            cnt_q       <= 2'd0;
            ack_q       <= 3'b000;
            grant_q     <= 3'b000;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM with read latency, transaction-level
// round-robin reference model, directed scenarios followed by randomized rounds.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic       clka = 1'b0;
    logic       restart;
    logic [2:0] req;
    logic       we2;
    logic [7:0] addr0, addr1, addr2, wdata0, wdata2;
    logic       lock;
    logic [2:0] ack, grant;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       busy, mem_en, mem_we;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(L)) dut (
        .clka(clka), .restart(restart), .req(req), .we2(we2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata2(wdata2), .lock(lock),
        .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clka = ~clka;

    function automatic logic [7:0] init_val(input int i);
        if (i == 8'h20) return 8'h3C;
        return 8'(i * 37 + 11);
    endfunction

    // Memory macro: data appears L cycles after the mem_en cycle, garbage otherwise.
    logic [7:0] mem [256];
    logic [7:0] rd_pipe [L];
    logic       mem_ready = 1'b0;
    always @(posedge clka) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata;
    int         rr;
    int         total = 0;
    int         bad = 0;
    logic [2:0] last_ack;
    int         exp_order [6] = '{0, 1, 2, 0, 1, 2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] d, input logic w);
        req[i] = 1'b1;
        case (i)
            0: begin addr0 = a; wdata0 = d; end
            1: addr1 = a;
            default: begin addr2 = a; wdata2 = d; we2 = w; end
        endcase
    endtask

    task automatic do_reset();
        restart = 1'b1;
        step();
        step();
        restart = 1'b0;
        rr = 2;
        exp_rdata = 8'h00;
    endtask

    // One arbitration from the current IDLE cycle through to the following IDLE cycle.
    task automatic run_txn();
        logic [2:0] elig;
        int         win;
        logic       w;
        logic [7:0] a, d;
        int         cyc, extra;
        logic       saved_lock;
        last_ack = 3'b000;
        elig = lock ? (req & 3'b001) : req;
        if (elig == 3'b000) begin
            step();
            check_eq("idle_grant", grant, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_mem_en", mem_en, 0);
            return;
        end
        win = -1;
        for (int k = 1; k <= 3; k++) begin
            if (win < 0 && elig[(rr + k) % 3]) win = (rr + k) % 3;
        end
        w = (win == 0) ? 1'b1 : (win == 1) ? 1'b0 : we2;
        a = (win == 0) ? addr0 : (win == 1) ? addr1 : addr2;
        d = (win == 0) ? wdata0 : wdata2;
        saved_lock = lock;
        step();
        check_eq("issue_en", mem_en, 1);
        check_eq("issue_we", mem_we, w);
        check_eq("issue_addr", mem_addr, a);
        if (w) check_eq("issue_wdata", mem_wdata, d);
        check_eq("issue_grant", grant, 3'b001 << win);
        check_eq("issue_busy", busy, 1);
        lock = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) req[win] = 1'b0;
        cyc = 1;
        extra = 0;
        while (ack == 3'b000 && cyc < 12) begin
            step();
            cyc++;
            if (mem_en) extra++;
        end
        last_ack = ack;
        check_eq("ack_latency", cyc, w ? 2 : 2 + L);
        check_eq("ack_value", ack, 3'b001 << win);
        check_eq("ack_grant", grant, 3'b001 << win);
        check_eq("single_mem_en", extra, 0);
        if (w) ref_mem[a] = d;
        else   exp_rdata = ref_mem[a];
        check_eq("rdata", rdata, exp_rdata);
        rr = win;
        req[win] = 1'b0;
        lock = saved_lock;
        step();
        check_eq("post_ack", ack, 0);
        check_eq("post_grant", grant, 0);
        check_eq("post_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        req = 3'b000; we2 = 1'b0; lock = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00; wdata0 = 8'h00; wdata2 = 8'h00;
        do_reset();
        check_eq("rst_ack", ack, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_rdata", rdata, 0);

        // Single loader write, then single fetch read of preloaded 3C.
        raise(0, 8'h10, 8'hA5, 1'b1);
        run_txn();
        check_eq("wr_ack001", last_ack, 3'b001);
        raise(1, 8'h20, 8'h00, 1'b0);
        run_txn();
        check_eq("rd_ack010", last_ack, 3'b010);
        check_eq("rd_data3c", rdata, 8'h3C);

        // Reset while a read sits in WAIT: everything drops, no ack, loader wins next.
        raise(1, 8'h21, 8'h00, 1'b0);
        step();
        step();
        #2 restart = 1'b1;
        #1;
        check_eq("midrst_mem_en", mem_en, 0);
        check_eq("midrst_ack", ack, 0);
        check_eq("midrst_grant", grant, 0);
        check_eq("midrst_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("midrst_no_ack", ack, 0);
        end
        restart = 1'b0;
        rr = 2;
        exp_rdata = 8'h00;
        check_eq("midrst_rdata", rdata, 0);
        raise(0, 8'h11, 8'h5A, 1'b1);
        run_txn();
        check_eq("midrst_first0", last_ack, 3'b001);
        run_txn();
        check_eq("midrst_then1", last_ack, 3'b010);

        // All three held and re-raised: strict rotation from reset.
        do_reset();
        raise(0, 8'h30, 8'h01, 1'b1);
        raise(1, 8'h31, 8'h00, 1'b0);
        raise(2, 8'h32, 8'h02, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_txn();
            check_eq("rr_order", last_ack, 3'b001 << exp_order[i]);
            case (exp_order[i])
                0: raise(0, 8'h30, 8'(i), 1'b1);
                1: raise(1, 8'h31, 8'h00, 1'b0);
                default: raise(2, 8'h32, 8'(i + 8'h40), 1'b1);
            endcase
        end
        req = 3'b000;
        step();

        // Lock: requesters 1/2 starve until the loader asks; after unlock, 1 then 2.
        lock = 1'b1;
        raise(1, 8'h50, 8'h00, 1'b0);
        raise(2, 8'h51, 8'h33, 1'b1);
        run_txn();
        run_txn();
        raise(0, 8'h52, 8'h44, 1'b1);
        run_txn();
        check_eq("lock_serve0", last_ack, 3'b001);
        lock = 1'b0;
        run_txn();
        check_eq("unlock_serve1", last_ack, 3'b010);
        run_txn();
        check_eq("unlock_serve2", last_ack, 3'b100);

        // Data path read then write of the same word; write leaves rdata alone.
        raise(2, 8'h60, 8'h99, 1'b0);
        run_txn();
        check_eq("dp_read_old", rdata, init_val(8'h60));
        raise(2, 8'h60, 8'h77, 1'b1);
        run_txn();
        check_eq("dp_write_keep", rdata, init_val(8'h60));
        raise(2, 8'h60, 8'h00, 1'b0);
        run_txn();
        check_eq("dp_read_new", rdata, 8'h77);

        for (int r = 0; r < 200; r++) begin
            lock = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1)
                    raise(i, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            run_txn();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
